fetch_stage_ctrl: RTL and testbench
===================================

// Module: fetch_stage_ctrl
// PURPOSE
//  Consumes the stall controls produced by the hazard detection unit.
//  Owns the PC register and the IF/ID pipeline register. Applies hold on a stall and
//  NOP-injection on a branch flush.
//  Sits between instruction memory (combinational read at pc_o) and the ID stage.
// PARAMETERS
//  ADDR_W    32            PC / address width
//  INSTR_W   32            instruction width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
//  NOP_INSTR 32'h0000_0000 word injected into IF/ID on flush/reset (sll $0,$0,0)
// PORTS
//  clk_i            in   1        clock, rising edge
//  rst_i            in   1        asynchronous, active-low reset
//  start_i          in   1        1 = PC may advance; 0 = PC and IF/ID hold
//  pc_stall_i       in   1        1 = hold PC (from hazard unit pc_o)
//  if_id_stall_i    in   1        1 = hold IF/ID (from hazard unit if_id_o)
//  flush_i          in   1        1 = branch/jump taken in ID; redirect + squash
//  target_i         in   ADDR_W   redirect address, valid when flush_i=1
//  instr_i          in   INSTR_W  instruction memory data for pc_o
//  pc_o             out  ADDR_W   current fetch address
//  if_id_pc4_o      out  ADDR_W   registered PC+4 of instruction in IF/ID
//  if_id_instr_o    out  INSTR_W  registered instruction in IF/ID
//  if_id_valid_o    out  1        1 = IF/ID holds a real (non-squashed) instruction
//  stall_cnt_o      out  16       cycles with pc_stall_i=1 (only with STALL_CNT_EN)
//  flush_cnt_o      out  16       flushes taken (only with STALL_CNT_EN)
// BEHAVIOUR
//  Reset (rst_i=0, async, any time incl. mid-stall):
//   - pc_o=RESET_PC, if_id_instr_o=NOP_INSTR, if_id_pc4_o=0, if_id_valid_o=0, counters=0.
//   - Outputs follow reset immediately, not at the next edge.
//  States (2-bit FSM):
//   IDLE  -> RUN when start_i=1.
//   RUN   -> HOLD when pc_stall_i|if_id_stall_i and !flush_i.
//   HOLD  -> RUN when both stalls drop.
//   RUN/HOLD -> IDLE when start_i=0.
//  Per-edge priority (highest first):
//   1 start_i=0: pc_o and IF/ID unchanged.
//   2 flush_i=1: pc_o<=target_i; IF/ID<=NOP_INSTR, valid<=0, pc4<=0.
//     Flush overrides both stalls in the same cycle.
//   3 Stalls are independent:
//     - pc_stall_i=1: pc_o unchanged; else pc_o<=pc_o+4.
//     - if_id_stall_i=1: IF/ID unchanged; else IF/ID<={instr_i, pc_o+4}, valid<=1.
//  Latency: instr_i at pc_o appears on if_id_instr_o one edge later.
//   - A 1-cycle stall delays the IF/ID update by exactly one edge.
//   - Hold lasts as many cycles as the stall input stays high; no internal limit.
//  Arithmetic: pc_o+4 is modulo 2^ADDR_W (0xFFFF_FFFC -> 0x0000_0000, no error).
//   - Low two bits of target_i are forced to 0.
//  Stall with if_id_stall_i=1, pc_stall_i=0 is legal:
//   - PC advances, IF/ID holds, and the fetched word is discarded.
//  No combinational path from any input to any output.
// CONFIGURATION
//  STALL_CNT_EN defined: stall_cnt_o increments every edge with pc_stall_i=1 and start_i=1.
//   - flush_cnt_o increments every edge with flush_i=1 and start_i=1.
//   - Both counters saturate at 16'hFFFF.
//  STALL_CNT_EN undefined: counters are not built; stall_cnt_o and flush_cnt_o tie to 0.
// STRUCTURE
//  Shared package pipe_pkg: ADDR_W/INSTR_W defaults, NOP_INSTR, RESET_PC,
//   fetch state typedef {IDLE,RUN,HOLD}, PC_INC=4.
//  One sub-module: pipe_reg (width-parameterised register).
//   - Async active-low reset value; ports en and clr; clr has priority over en.
//   - Used for the PC register and the IF/ID register.
// TESTING
//  1 Reset release with start_i=1, instr_i=0x2001_0005:
//    -> pc_o 0,4,8 on successive edges; after the first edge if_id_instr_o=0x2001_0005,
//       if_id_pc4_o=4, valid=1.
//  2 pc_stall_i=if_id_stall_i=1 for 2 cycles at pc_o=0x10:
//    -> pc_o stays 0x10 and IF/ID is unchanged for 2 edges; pc_o=0x14 on the following edge.
//  3 flush_i=1, target_i=0x40, both stalls=1 in the same cycle:
//    -> pc_o=0x40, if_id_instr_o=NOP_INSTR, valid=0.
//  4 pc_o=0xFFFF_FFFC, no stall -> pc_o=0x0000_0000 next edge.
//  5 rst_i pulled low mid-stall between edges:
//    -> pc_o=RESET_PC and valid=0 immediately, before the next clk_i edge.
//  6 With STALL_CNT_EN, 3 stall cycles and 1 flush -> stall_cnt_o=3, flush_cnt_o=1.
//    Without it both read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the fetch stage:
//   ADDR_W / INSTR_W   default address and instruction widths
//   RESET_PC           PC value after reset
//   NOP_INSTR          word placed in IF/ID on reset and on flush (sll $0,$0,0)
//   PC_INC             sequential fetch increment
//   fetch_state_t      fetch controller state {IDLE, RUN, HOLD}
//   sat_inc16()        16-bit saturating increment used by the event counters
// ----------------------------------------------------------------------------
package pipe_pkg;

  localparam int          ADDR_W    = 32;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } fetch_state_t;

  // Counts stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// ----------------------------------------------------------------------------
// pipe_reg
// Width-parameterised pipeline register with asynchronous active-low reset.
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset, loads RST_VAL
//   en     in   1   load d on the next edge
//   clr    in   1   load RST_VAL on the next edge (wins over en)
//   d      in   W   next value
//   q      out  W   registered value
// ----------------------------------------------------------------------------
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage: clear beats load, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_stage_ctrl
// Owns the PC and the IF/ID pipeline register. Applies hazard-unit stalls
// (hold) and branch flushes (redirect + NOP injection). Instruction memory is
// read combinationally at pc_o; its data is captured into IF/ID.
// Optional build macro: STALL_CNT_EN enables the stall/flush event counters;
// without it stall_cnt_o and flush_cnt_o are constant zero.
// Ports:
//   clk_i          in   1        clock, rising edge
//   rst_i          in   1        asynchronous active-low reset
//   start_i        in   1        1 = PC/IF-ID may update, 0 = everything holds
//   pc_stall_i     in   1        hold PC
//   if_id_stall_i  in   1        hold IF/ID
//   flush_i        in   1        redirect to target_i and squash IF/ID
//   target_i       in   ADDR_W   redirect address (low two bits ignored)
//   instr_i        in   INSTR_W  instruction memory data at pc_o
//   pc_o           out  ADDR_W   current fetch address
//   if_id_pc4_o    out  ADDR_W   PC+4 of the instruction in IF/ID
//   if_id_instr_o  out  INSTR_W  instruction in IF/ID
//   if_id_valid_o  out  1        IF/ID holds a real instruction
//   stall_cnt_o    out  16       edges with pc_stall_i=1 while started
//   flush_cnt_o    out  16       flushes taken while started
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module fetch_stage_ctrl #(
  parameter int                 ADDR_W    = pipe_pkg::ADDR_W,
  parameter int                 INSTR_W   = pipe_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               pc_stall_i,
  input  logic               if_id_stall_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  target_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  if_id_pc4_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic               if_id_valid_o,
  output logic [15:0]        stall_cnt_o,
  output logic [15:0]        flush_cnt_o
);

  import pipe_pkg::*;

  // IF/ID packed as {valid, pc4, instr}; reset and flush share one value.
  localparam int                IFID_W   = 1 + ADDR_W + INSTR_W;
  localparam logic [IFID_W-1:0] IFID_RST = {1'b0, {ADDR_W{1'b0}}, NOP_INSTR};

  fetch_state_t        state;
  fetch_state_t        state_next;
  logic                go;
  logic                pc_en;
  logic [ADDR_W-1:0]   pc_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_plus4;
  logic [ADDR_W-1:0]   target_al;
  logic                ifid_en;
  logic                ifid_clr;
  logic [IFID_W-1:0]   ifid_d;
  logic [IFID_W-1:0]   ifid_q;

  // Wraps modulo 2^ADDR_W by construction.
  assign pc_plus4  = pc_q + ADDR_W'(PC_INC);
  assign target_al = {target_i[ADDR_W-1:2], 2'b00};

  // Fetch controller state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and register-enable decode.
  always_comb begin
    state_next = state;
    go         = 1'b0;
    pc_en      = 1'b0;
    pc_d       = pc_plus4;
    ifid_en    = 1'b0;
    ifid_clr   = 1'b0;
    ifid_d     = {1'b1, pc_plus4, instr_i};

    case (state)
      IDLE: begin
        go = start_i;
        if (start_i) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        go = start_i;
        if (!start_i) begin
          state_next = IDLE;
        end else if ((pc_stall_i || if_id_stall_i) && !flush_i) begin
          state_next = HOLD;
        end else begin
          state_next = RUN;
        end
      end
      HOLD: begin
        go = start_i;
        if (!start_i) begin
          state_next = IDLE;
        end else if (!pc_stall_i && !if_id_stall_i) begin
          state_next = RUN;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        go         = 1'b0;
        state_next = IDLE;
      end
    endcase

    // The IDLE->RUN transition edge already fetches: start_i alone gates updates.
    if (go) begin
      if (flush_i) begin
        pc_en    = 1'b1;
        pc_d     = target_al;
        ifid_clr = 1'b1;
      end else begin
        pc_en   = !pc_stall_i;
        ifid_en = !if_id_stall_i;
      end
    end else begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ifid_clr = 1'b0;
    end
  end

  pipe_reg #(
    .W       (ADDR_W),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (pc_en),
    .clr   (1'b0),
    .d     (pc_d),
    .q     (pc_q)
  );

  pipe_reg #(
    .W       (IFID_W),
    .RST_VAL (IFID_RST)
  ) u_if_id_reg (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (ifid_en),
    .clr   (ifid_clr),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign pc_o          = pc_q;
  assign if_id_valid_o = ifid_q[IFID_W-1];
  assign if_id_pc4_o   = ifid_q[IFID_W-2 -: ADDR_W];
  assign if_id_instr_o = ifid_q[INSTR_W-1:0];

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Saturating event counters; a flush edge with pc_stall_i=1 counts in both.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (start_i && pc_stall_i) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (start_i && flush_i) begin
        flush_cnt <= sat_inc16(flush_cnt);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = 16'h0000;
  assign flush_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage_ctrl
// Scoreboard bench: each driven cycle updates a reference model of the fetch
// stage and pushes the expected post-edge outputs; each test task pops and
// compares after the edge.
// ----------------------------------------------------------------------------
module tb_fetch_stage_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        pc_stall_i;
  logic        if_id_stall_i;
  logic        flush_i;
  logic [31:0] target_i;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [15:0] m_sc;
  logic [15:0] m_fc;

  always #5 clk_i = ~clk_i;

  fetch_stage_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .pc_stall_i    (pc_stall_i),
    .if_id_stall_i (if_id_stall_i),
    .flush_i       (flush_i),
    .target_i      (target_i),
    .instr_i       (instr_i),
    .pc_o          (pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_valid_o (if_id_valid_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_sc = 16'h0; m_fc = 16'h0;
    sb.delete();
  endtask

  // Drive one cycle, advance the model, push the expectation, wait past the edge.
  task automatic step(input logic st, input logic ps, input logic is, input logic fl,
                      input logic [31:0] tgt, input logic [31:0] ins);
    logic [31:0] old_pc;
    start_i = st; pc_stall_i = ps; if_id_stall_i = is; flush_i = fl;
    target_i = tgt; instr_i = ins;
    old_pc = m_pc;
    if (st) begin
      if (fl) begin
        m_pc = tgt & 32'hFFFF_FFFC;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else begin
        if (!is) begin
          m_instr = ins; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
        end
        if (!ps) m_pc = old_pc + 32'd4;
      end
`ifdef STALL_CNT_EN
      if (ps && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (fl && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
`endif
    end
    sb.push_back('{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, sc: m_sc, fc: m_fc});
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; pc_stall_i = 1'b0; if_id_stall_i = 1'b0;
    flush_i = 1'b0; target_i = 32'h0; instr_i = 32'h0;
    model_reset();
    #2;
    checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h exp %h", pc_o, 32'h0); end
    checks++; if (if_id_instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h exp %h", if_id_instr_o, 32'h0); end
    checks++; if (if_id_pc4_o !== 32'h0) begin failures++; $display("FAIL reset_pc4: got %h exp %h", if_id_pc4_o, 32'h0); end
    checks++; if (if_id_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", if_id_valid_o); end
    checks++; if (stall_cnt_o !== 16'h0 || flush_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_cnt: got %h/%h exp 0/0", stall_cnt_o, flush_cnt_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_run();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2001_0005);
      e = sb.pop_front();
      checks++; if (pc_o !== e.pc) begin failures++; $display("FAIL run_pc[%0d]: got %h exp %h", i, pc_o, e.pc); end
      checks++; if (if_id_instr_o !== e.instr || if_id_pc4_o !== e.pc4 || if_id_valid_o !== e.valid)
        begin failures++; $display("FAIL run_ifid[%0d]: got %h/%h/%b exp %h/%h/%b", i, if_id_instr_o, if_id_pc4_o, if_id_valid_o, e.instr, e.pc4, e.valid); end
    end
    // Explicit spec values after three edges from reset
    checks++; if (pc_o !== 32'hC || if_id_pc4_o !== 32'hC) begin failures++; $display("FAIL run_abs: got pc %h pc4 %h exp c/c", pc_o, if_id_pc4_o); end
  endtask

  task automatic test_stall();
    logic [2:0] pat [0:7];
    pat[0] = 3'b000; // bring pc to 0x10
    pat[1] = 3'b110; pat[2] = 3'b110; // both stalls for 2 cycles
    pat[3] = 3'b000; // release -> 0x14
    pat[4] = 3'b010; // if_id stall only: pc advances, word discarded
    pat[5] = 3'b100; // pc stall only: IF/ID takes the same pc again
    pat[6] = 3'b000;
    pat[7] = 3'b000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[i][2], pat[i][1], 1'b0, 32'h0, 32'h1000_0000 + i);
      e = sb.pop_front();
      checks++; if (pc_o !== e.pc) begin failures++; $display("FAIL stall_pc[%0d]: got %h exp %h", i, pc_o, e.pc); end
      checks++; if (if_id_instr_o !== e.instr || if_id_pc4_o !== e.pc4 || if_id_valid_o !== e.valid)
        begin failures++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b exp %h/%h/%b", i, if_id_instr_o, if_id_pc4_o, if_id_valid_o, e.instr, e.pc4, e.valid); end
      if (i == 3) begin
        checks++; if (pc_o !== 32'h14) begin failures++; $display("FAIL stall_release: got %h exp %h", pc_o, 32'h14); end
      end
    end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'hAAAA_5555);
    e = sb.pop_front();
    checks++; if (pc_o !== e.pc || pc_o !== 32'h40) begin failures++; $display("FAIL flush_pc: got %h exp %h", pc_o, e.pc); end
    checks++; if (if_id_instr_o !== e.instr || if_id_pc4_o !== e.pc4 || if_id_valid_o !== 1'b0)
      begin failures++; $display("FAIL flush_ifid: got %h/%h/%b exp %h/%h/0", if_id_instr_o, if_id_pc4_o, if_id_valid_o, e.instr, e.pc4); end
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0123, 32'h1);
    e = sb.pop_front();
    checks++; if (pc_o !== e.pc) begin failures++; $display("FAIL flush_align: got %h exp %h", pc_o, e.pc); end
    // start_i=0 freezes everything, even a flush
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h800, 32'h2);
    e = sb.pop_front();
    checks++; if (pc_o !== e.pc || if_id_instr_o !== e.instr || if_id_valid_o !== e.valid)
      begin failures++; $display("FAIL idle_hold: got %h/%h/%b exp %h/%h/%b", pc_o, if_id_instr_o, if_id_valid_o, e.pc, e.instr, e.valid); end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    e = sb.pop_front();
    checks++; if (pc_o !== e.pc) begin failures++; $display("FAIL wrap_setup: got %h exp %h", pc_o, e.pc); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3C00_1234);
    e = sb.pop_front();
    checks++; if (pc_o !== e.pc || pc_o !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h exp %h", pc_o, e.pc); end
    checks++; if (if_id_pc4_o !== e.pc4 || if_id_instr_o !== e.instr) begin failures++; $display("FAIL wrap_ifid: got %h/%h exp %h/%h", if_id_pc4_o, if_id_instr_o, e.pc4, e.instr); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h5);
    void'(sb.pop_front());
    start_i = 1'b1; pc_stall_i = 1'b1; if_id_stall_i = 1'b1; flush_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL async_pc: got %h exp %h", pc_o, 32'h0); end
    checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin failures++; $display("FAIL async_ifid: got %b/%h exp 0/0", if_id_valid_o, if_id_instr_o); end
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_counters();
    logic [15:0] want_sc;
    logic [15:0] want_fc;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h7);
      void'(sb.pop_front());
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h7);
    e = sb.pop_front();
`ifdef STALL_CNT_EN
    want_sc = 16'd3; want_fc = 16'd1;
`else
    want_sc = 16'd0; want_fc = 16'd0;
`endif
    checks++; if (stall_cnt_o !== e.sc || stall_cnt_o !== want_sc) begin failures++; $display("FAIL stall_cnt: got %0d exp %0d", stall_cnt_o, want_sc); end
    checks++; if (flush_cnt_o !== e.fc || flush_cnt_o !== want_fc) begin failures++; $display("FAIL flush_cnt: got %0d exp %0d", flush_cnt_o, want_fc); end
    checks++; if (pc_o !== e.pc) begin failures++; $display("FAIL cnt_pc: got %h exp %h", pc_o, e.pc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_flush();
    test_wrap();
    test_async_reset();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
